trap_dump_ctrl: RTL and testbench

Synthesizable end-of-program controller for the pipelined CPU test harness. Watches the decode-stage instruction stream for a trap word and requests a pipeline halt. After a drain interval it sequences reads over a parametrised DMEM window and streams each word out on a valid/ready port. A cycle watchdog flags programs that never trap.

---
 rtl/trap_dump_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_trap_dump_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_dump_ctrl.sv
// trap_dump_ctrl: halts on trap word, drains, dumps a DMEM window
// over valid/ready; cycle watchdog flags programs that never trap.
//
// Ports:
//   clock, reset               rising-edge clock, sync active-high reset
//   instr_in, instr_valid      decode-stage instruction stream
//   halt_req                   freeze-fetch request (sticky)
//   mem_rd_en, mem_addr        one-cycle DMEM read strobe and address
//   mem_rd_data                DMEM data, one cycle after mem_rd_en
//   dump_valid, dump_ready     beat handshake
//   dump_addr, dump_data       beat payload
//   dump_last                  final beat marker
//   busy, done, timeout        status flags
//
// Optional build macro: DUMP_CHECKSUM_EN appends one checksum beat
// (sum of dumped words) after the last data word.

module trap_dump_ctrl #(
    parameter int                WORD_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [WORD_W-1:0] TRAP_WORD   = 32'h44000300,
    parameter int                DRAIN_CYC   = 5,
    parameter int                DUMP_BASE   = 8192,
    parameter int                DUMP_WORDS  = 10,
    parameter int                STRIDE      = 4,
    parameter int                TIMEOUT_CYC = 25000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] instr_in,
    input  logic              instr_valid,
    output logic              halt_req,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WT    = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_TMO   = 3'd6;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYC - 1);
    localparam logic [31:0] IDX_LAST   = 32'(DUMP_WORDS - 1);
    localparam logic [31:0] WDOG_LAST  = 32'(TIMEOUT_CYC - 1);

    // With no drain interval the single DRAIN cycle doubles as
    // the first read, so the first beat lands 3 cycles after trap.
    localparam bit DRAIN_RD = (DRAIN_CYC == 0) && (DUMP_WORDS != 0);

    logic [2:0]  state;
    logic [31:0] wdog;
    logic [31:0] dcnt;
    logic [31:0] idx;
    logic        trap;

`ifdef DUMP_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    logic              csum_beat;
`endif

    assign trap = instr_valid && (instr_in == TRAP_WORD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            wdog       <= '0;
            dcnt       <= '0;
            idx        <= '0;
            halt_req   <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum        <= '0;
            csum_beat  <= 1'b0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    wdog <= wdog + 32'd1;
                    // trap beats the watchdog on the same cycle
                    if (trap) begin
                        state    <= S_DRAIN;
                        halt_req <= 1'b1;
                        busy     <= 1'b1;
                        dcnt     <= '0;
                        if (DRAIN_RD) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= BASE;
                        end
                    end else if (TIMEOUT_CYC != 0 &&
                                 wdog == WDOG_LAST) begin
                        state   <= S_TMO;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 32'd1;
                    if (DRAIN_CYC == 0 || dcnt == DRAIN_LAST) begin
                        if (DRAIN_RD) begin
                            state <= S_WT;
                        end else if (DUMP_WORDS != 0) begin
                            state     <= S_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= BASE;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            state      <= S_OUT;
                            dump_valid <= 1'b1;
                            dump_addr  <= BASE;
                            dump_data  <= sum;
                            dump_last  <= 1'b1;
                            csum_beat  <= 1'b1;
`else
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end
                    end
                end
                S_RD: begin
                    state <= S_WT;
                end
                S_WT: begin
                    state      <= S_OUT;
                    dump_valid <= 1'b1;
                    dump_addr  <= mem_addr;
                    dump_data  <= mem_rd_data;
`ifdef DUMP_CHECKSUM_EN
                    sum        <= sum + mem_rd_data;
                    dump_last  <= 1'b0;
`else
                    dump_last  <= (idx == IDX_LAST);
`endif
                end
                S_OUT: begin
                    if (dump_ready) begin
                        idx        <= idx + 32'd1;
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        if (csum_beat) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (idx == IDX_LAST) begin
                            // checksum beat needs no DMEM read
                            dump_valid <= 1'b1;
                            dump_addr  <= dump_addr + STEP;
                            dump_data  <= sum;
                            dump_last  <= 1'b1;
                            csum_beat  <= 1'b1;
                        end else begin
                            state     <= S_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= dump_addr + STEP;
                        end
`else
                        if (idx == IDX_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= dump_addr + STEP;
                        end
`endif
                    end
                end
                S_DONE, S_TMO: begin
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_dump_ctrl.sv
// tb_trap_dump_ctrl: scoreboard bench for trap_dump_ctrl.
// Three instances: main (watchdog 100), drain0/one-word, zero-word.

module tb_trap_dump_ctrl;

    localparam logic [31:0] TRAP = 32'h44000300;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int NB0 = CS ? 11 : 10;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic        iv0, iv1;

    logic        halt0, rd0, v0, rdy0, l0, busy0, done0, tmo0;
    logic [31:0] ma0, rdat0, a0, d0;
    logic        halt1, rd1, v1, l1, busy1, done1, tmo1;
    logic [31:0] ma1, rdat1, a1, d1;
    logic        halt2, rd2, v2, l2, busy2, done2, tmo2;
    logic [31:0] ma2, rdat2, a2, d2;
    logic        rdy12;

    int chk, pass;
    int rc0, rc1, rc2;
    int n0, n1, n2;
    int rb0, rb1, rb2, nb, lat, f1, k, rs;

    trap_dump_ctrl #(.TIMEOUT_CYC(100)) u0 (
        .clock(clk), .reset(reset),
        .instr_in(instr_in), .instr_valid(iv0),
        .halt_req(halt0), .mem_rd_en(rd0), .mem_addr(ma0),
        .mem_rd_data(rdat0), .dump_valid(v0), .dump_ready(rdy0),
        .dump_addr(a0), .dump_data(d0), .dump_last(l0),
        .busy(busy0), .done(done0), .timeout(tmo0)
    );

    trap_dump_ctrl #(
        .DRAIN_CYC(0), .DUMP_WORDS(1), .TIMEOUT_CYC(0)
    ) u1 (
        .clock(clk), .reset(reset),
        .instr_in(instr_in), .instr_valid(iv1),
        .halt_req(halt1), .mem_rd_en(rd1), .mem_addr(ma1),
        .mem_rd_data(rdat1), .dump_valid(v1), .dump_ready(rdy12),
        .dump_addr(a1), .dump_data(d1), .dump_last(l1),
        .busy(busy1), .done(done1), .timeout(tmo1)
    );

    trap_dump_ctrl #(
        .DUMP_WORDS(0), .TIMEOUT_CYC(0)
    ) u2 (
        .clock(clk), .reset(reset),
        .instr_in(instr_in), .instr_valid(iv1),
        .halt_req(halt2), .mem_rd_en(rd2), .mem_addr(ma2),
        .mem_rd_data(rdat2), .dump_valid(v2), .dump_ready(rdy12),
        .dump_addr(a2), .dump_data(d2), .dump_last(l2),
        .busy(busy2), .done(done2), .timeout(tmo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM[8192..8228] holds 1..10; anything else is junk
    function automatic logic [31:0] dmem(input logic [31:0] a);
        if (a >= 32'd8192 && a < 32'd8232 && a[1:0] == 2'b00)
            return ((a - 32'd8192) >> 2) + 32'd1;
        return 32'hBAD00000 ^ a;
    endfunction

    initial begin
        rc0 = 0; rc1 = 0; rc2 = 0;
        n0 = 0; n1 = 0; n2 = 0;
    end

    always @(posedge clk) begin
        if (rd0) begin
            rdat0 <= dmem(ma0);
            rc0   <= rc0 + 1;
        end
        if (rd1) begin
            rdat1 <= dmem(ma1);
            rc1   <= rc1 + 1;
        end
        if (rd2) begin
            rdat2 <= dmem(ma2);
            rc2   <= rc2 + 1;
        end
    end

    task automatic check(input string nm,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        chk++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, exp);
    endtask

    task automatic cmp_beat(input string nm, input beat_t e,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            input logic l);
        check({nm, " addr"}, a, e.a);
        check({nm, " data"}, d, e.d);
        check({nm, " last"}, l, e.l);
    endtask

    task automatic extra(input string nm, input logic [31:0] a);
        chk++;
        $display("FAIL %s extra beat: got addr %0h want none", nm, a);
    endtask

    always @(negedge clk) begin
        if (!reset && v0 && rdy0) begin
            n0 <= n0 + 1;
            if (q0.size() == 0) extra("u0", a0);
            else cmp_beat("u0", q0.pop_front(), a0, d0, l0);
        end
        if (!reset && v1 && rdy12) begin
            n1 <= n1 + 1;
            if (q1.size() == 0) extra("u1", a1);
            else cmp_beat("u1", q1.pop_front(), a1, d1, l1);
        end
        if (!reset && v2 && rdy12) begin
            n2 <= n2 + 1;
            if (q2.size() == 0) extra("u2", a2);
            else cmp_beat("u2", q2.pop_front(), a2, d2, l2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iv0   = 1'b0;
        iv1   = 1'b0;
        tick();
        tick();
        q0.delete();
        q1.delete();
        q2.delete();
        reset = 1'b0;
    endtask

    task automatic push_dump0();
        for (int i = 0; i < 10; i++)
            q0.push_back('{a: 32'(8192 + 4 * i),
                           d: 32'(i + 1),
                           l: (i == 9) && !CS});
        if (CS) q0.push_back('{a: 32'd8232, d: 32'd55, l: 1'b1});
    endtask

    task automatic snap();
        rb0 = rc0; rb1 = rc1; rb2 = rc2; nb = n0;
    endtask

    task automatic trap0();
        instr_in = TRAP;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, " halt"}, halt0, 0);
        check({nm, " rd_en"}, rd0, 0);
        check({nm, " mem_addr"}, ma0, 0);
        check({nm, " valid"}, v0, 0);
        check({nm, " addr"}, a0, 0);
        check({nm, " data"}, d0, 0);
        check({nm, " last"}, l0, 0);
        check({nm, " busy"}, busy0, 0);
        check({nm, " done"}, done0, 0);
        check({nm, " timeout"}, tmo0, 0);
    endtask

    task automatic wait_done0(input string nm);
        int j;
        j = 0;
        while (!done0 && j < 300) begin
            tick();
            j++;
        end
        check({nm, " done"}, done0, 1);
        check({nm, " busy"}, busy0, 0);
        check({nm, " valid"}, v0, 0);
        check({nm, " beats"}, n0 - nb, NB0);
        check({nm, " reads"}, rc0 - rb0, 10);
        check({nm, " queue"}, q0.size(), 0);
    endtask

    task automatic wait_valid0(input string nm);
        int j;
        j = 0;
        while (!v0 && j < 50) begin
            tick();
            j++;
        end
        check({nm, " valid seen"}, v0, 1);
    endtask

    task automatic wait_beats0(input int n);
        int j;
        j = 0;
        while (n0 - nb < n && j < 200) begin
            tick();
            j++;
        end
        check("beats reached", n0 - nb, n);
    endtask

    initial begin
        chk = 0; pass = 0;
        reset = 1'b1; instr_in = '0;
        iv0 = 1'b0; iv1 = 1'b0;
        rdy0 = 1'b1; rdy12 = 1'b1;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;

        // dump with sink always ready; second trap in DRAIN
        push_dump0();
        q1.push_back('{a: 32'd8192, d: 32'd1, l: !CS});
        if (CS) begin
            q1.push_back('{a: 32'd8196, d: 32'd1, l: 1'b1});
            q2.push_back('{a: 32'd8192, d: 32'd0, l: 1'b1});
        end
        snap();
        repeat (19) tick();
        instr_in = TRAP;
        iv0 = 1'b1;
        iv1 = 1'b1;
        tick();
        check("A halt", halt0, 1);
        check("A busy", busy0, 1);
        lat = 1;
        f1 = 0;
        while (!v0 && lat < 40) begin
            if (v1 && f1 == 0) f1 = lat;
            tick();
            lat++;
            if (lat == 2) begin
                iv0 = 1'b0;
                iv1 = 1'b0;
            end
        end
        check("A first beat latency", lat, 8);
        check("u1 first beat latency", f1, 3);
        wait_done0("A");
        check("A halt held", halt0, 1);
        check("A timeout", tmo0, 0);
        check("u1 reads", rc1 - rb1, 1);
        check("u1 done", done1, 1);
        check("u1 queue", q1.size(), 0);
        check("u2 reads", rc2 - rb2, 0);
        check("u2 done", done2, 1);
        check("u2 queue", q2.size(), 0);

        // backpressure on beat 3
        do_reset();
        push_dump0();
        snap();
        repeat (3) tick();
        trap0();
        wait_beats0(2);
        rdy0 = 1'b0;
        wait_valid0("B");
        rs = rc0;
        for (int i = 0; i < 7; i++) begin
            check("B stall valid", v0, 1);
            check("B stall addr", a0, 32'd8200);
            check("B stall data", d0, 32'd3);
            check("B stall rd_en", rd0, 0);
            tick();
        end
        check("B stall reads", rc0 - rs, 0);
        rdy0 = 1'b1;
        wait_done0("B");

        // reset during beat 5, then fresh dump
        do_reset();
        push_dump0();
        snap();
        repeat (2) tick();
        trap0();
        wait_beats0(4);
        rdy0 = 1'b0;
        wait_valid0("C");
        check("C beat5 addr", a0, 32'd8208);
        check("C beat5 data", d0, 32'd5);
        reset = 1'b1;
        tick();
        check_zero("C mid reset");
        q0.delete();
        reset = 1'b0;
        rdy0 = 1'b1;
        tick();
        check("C idle valid", v0, 0);
        check("C idle halt", halt0, 0);
        push_dump0();
        snap();
        trap0();
        wait_done0("C");

        // watchdog expiry, no trap
        do_reset();
        snap();
        repeat (99) tick();
        check("D pre timeout", tmo0, 0);
        check("D pre done", done0, 0);
        tick();
        check("D timeout", tmo0, 1);
        check("D done", done0, 1);
        check("D busy", busy0, 0);
        check("D halt", halt0, 0);
        trap0();
        repeat (4) tick();
        check("D trap ignored", halt0, 0);
        check("D reads", rc0 - rb0, 0);
        check("D beats", n0 - nb, 0);
        check("D timeout held", tmo0, 1);

        // trap on the watchdog limit cycle wins
        do_reset();
        push_dump0();
        snap();
        repeat (99) tick();
        trap0();
        check("E timeout", tmo0, 0);
        check("E halt", halt0, 1);
        wait_done0("E");
        check("E timeout end", tmo0, 0);

        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time limit: got no finish want finish");
        $fatal(1);
    end

endmodule
